fetch_controller: RTL

Sequencing controller for the instruction-fetch stage. It drives `enablePC` and the next-address value of `programcounter`, selects between the sequential address from `adder` and a branch target, and runs the request/acknowledge handshake with instruction memory. It holds one fetched instruction in a single-entry buffer toward decode, with a valid/ready handshake. It sits between `programcounter`/`adder`, instruction memory and the decode stage.

---
 rtl/fetch_controller_buffer.sv | 4 +
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 39 +++
 rtl/fetch_controller.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fetch_controller_buffer.sv
// Buffer depth constant for the fetch stage; the holding register itself is in fetch_buffer.sv.
package fetch_controller_buffer_pkg;
  localparam int BUFFER_DEPTH = 1;
endpackage

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  localparam int ADDR_WIDTH_DEFAULT  = 32;
  localparam int INSTR_WIDTH_DEFAULT = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry instruction/PC holding register between fetch and decode.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   flush,
  input  logic                   ready,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0]  load_pc,
  output logic                   valid,
  output logic [INSTR_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0]  pc
);

  // Flush only drops the valid flag; the stale word is never presented to decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC load control, memory handshake and branch redirect.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEFAULT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  pcCurrent,
  input  logic [ADDR_WIDTH-1:0]  pcSeq,
  output logic                   enablePC,
  output logic [ADDR_WIDTH-1:0]  pcNext,
  output logic                   imemReq,
  output logic [ADDR_WIDTH-1:0]  imemAddr,
  input  logic                   imemAck,
  input  logic [INSTR_WIDTH-1:0] imemData,
  input  logic                   branchTaken,
  input  logic [ADDR_WIDTH-1:0]  branchTarget,
  output logic                   instrValid,
  input  logic                   instrReady,
  output logic [INSTR_WIDTH-1:0] instrOut,
  output logic [ADDR_WIDTH-1:0]  instrPc,
  output logic [31:0]            fetchCount
);

  fetch_state_t            state;
  fetch_state_t            next_state;
  logic [ADDR_WIDTH-1:0]   saved_target;
  logic                    save_target;
  logic                    buf_load;
  logic                    buf_flush;
  logic                    can_fetch;

  assign imemAddr  = pcCurrent;
  assign can_fetch = !instrValid || instrReady;

  fetch_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_buffer (
    .clock    (clock),
    .reset    (reset),
    .load     (buf_load),
    .flush    (buf_flush),
    .ready    (instrReady),
    .load_data(imemData),
    .load_pc  (pcCurrent),
    .valid    (instrValid),
    .data     (instrOut),
    .pc       (instrPc)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  // Redirect address held while a request is outstanding; latest branch wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saved_target <= '0;
    end else if (save_target) begin
      saved_target <= branchTarget;
    end else begin
      saved_target <= saved_target;
    end
  end

  // Delivered-instruction counter, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchCount <= 32'd0;
    end else if (instrValid && instrReady) begin
      fetchCount <= fetchCount + 32'd1;
    end else begin
      fetchCount <= fetchCount;
    end
  end

  // Next-state and PC/memory strobes; reset gates the combinational outputs too.
  always_comb begin
    next_state  = state;
    enablePC    = 1'b0;
    pcNext      = pcSeq;
    imemReq     = 1'b0;
    buf_load    = 1'b0;
    buf_flush   = 1'b0;
    save_target = 1'b0;
    if (reset) begin
      pcNext = RESET_VECTOR;
    end else begin
      case (state)
        BOOT: begin
          enablePC   = 1'b1;
          pcNext     = RESET_VECTOR;
          next_state = FETCH;
        end
        FETCH: begin
          imemReq = can_fetch;
          if (branchTaken) begin
            buf_flush = 1'b1;
            if (can_fetch && !imemAck) begin
              save_target = 1'b1;
              next_state  = FLUSH;
            end else begin
              enablePC = 1'b1;
              pcNext   = branchTarget;
            end
          end else if (can_fetch && imemAck) begin
            buf_load = 1'b1;
            enablePC = 1'b1;
          end else begin
            next_state = FETCH;
          end
        end
        FLUSH: begin
          imemReq   = 1'b1;
          buf_flush = 1'b1;
          if (imemAck) begin
            enablePC   = 1'b1;
            pcNext     = branchTaken ? branchTarget : saved_target;
            next_state = FETCH;
          end else if (branchTaken) begin
            save_target = 1'b1;
          end else begin
            next_state = FLUSH;
          end
        end
        default: begin
          next_state = BOOT;
        end
      endcase
    end
  end

endmodule
